// File: rtl/ex_result_buffer.sv
// Execute-stage result buffer: resolves the branch decision at push time and feeds the memory stage
// through a 2-entry in-order skid buffer. Optional flush port: define EX_RESULT_BUF_FLUSH_EN.
module ex_result_buffer #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_s,
  input  logic              alu_eq,
  input  logic              alu_ls,
  input  logic              alu_lu,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_is_branch,
  input  logic [2:0]        in_funct3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_is_branch,
  output logic              out_taken,
`ifdef EX_RESULT_BUF_FLUSH_EN
  input  logic              flush,
`endif
  output logic [1:0]        dbg_count
);

  localparam int E_W = DATA_W + REG_W + 2;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Handshake: a beat transfers on any rising edge where valid and ready are both high;
  // valid must not depend on ready, and in_ready is a register so out_ready never reaches it.
  logic [1:0]     r_count;
  logic [1:0]     w_count_nxt;
  logic           r_in_ready;
  logic [E_W-1:0] r_slot0;
  logic [E_W-1:0] r_slot1;
  logic [E_W-1:0] w_beat;
  logic           w_push;
  logic           w_pop;
  logic           w_flush;
  logic           w_taken;

`ifdef EX_RESULT_BUF_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign out_valid = (r_count != EMPTY);
  assign in_ready  = r_in_ready;
  assign w_push    = in_valid & r_in_ready;
  assign w_pop     = out_valid & out_ready;
  assign dbg_count = r_count;

  always_comb begin
    w_taken = 1'b0;
    if (in_is_branch) begin
      case (in_funct3)
        3'b000:  w_taken = alu_eq;
        3'b001:  w_taken = ~alu_eq;
        3'b100:  w_taken = alu_ls;
        3'b101:  w_taken = ~alu_ls;
        3'b110:  w_taken = alu_lu;
        3'b111:  w_taken = ~alu_lu;
        default: w_taken = 1'b0;
      endcase
    end
  end

  assign w_beat = {alu_s, in_rd, in_is_branch, w_taken};

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = EMPTY;
    end else begin
      case (r_count)
        EMPTY:   if (w_push) w_count_nxt = ONE;
        ONE: begin
          if (w_push && !w_pop)      w_count_nxt = FULL;
          else if (w_pop && !w_push) w_count_nxt = EMPTY;
        end
        FULL:    if (w_pop) w_count_nxt = ONE;
        default: w_count_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != FULL);
    end
  end

  // A flushed push is simply not written; stale slot data stays hidden behind out_valid=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else if (!w_flush) begin
      case (r_count)
        EMPTY: if (w_push) r_slot0 <= w_beat;
        ONE: begin
          if (w_push && w_pop) r_slot0 <= w_beat;
          else if (w_push)     r_slot1 <= w_beat;
        end
        FULL:    if (w_pop) r_slot0 <= r_slot1;
        default: ;
      endcase
    end
  end

  assign {out_result, out_rd, out_is_branch, out_taken} = r_slot0;

endmodule

// File: tb/tb_ex_result_buffer.sv
// Self-checking bench for ex_result_buffer: directed scenarios plus random traffic against a queue model.
module tb_ex_result_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_s;
  logic        alu_eq, alu_ls, alu_lu;
  logic [4:0]  in_rd;
  logic        in_is_branch;
  logic [2:0]  in_funct3;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_is_branch;
  logic        out_taken;
  logic        flush_i;
  logic [1:0]  dbg_count;

  always #5 clk = ~clk;

  ex_result_buffer #(.DATA_W(64), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_s(alu_s), .alu_eq(alu_eq), .alu_ls(alu_ls), .alu_lu(alu_lu),
    .in_rd(in_rd), .in_is_branch(in_is_branch), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_is_branch(out_is_branch), .out_taken(out_taken),
`ifdef EX_RESULT_BUF_FLUSH_EN
    .flush(flush_i),
`endif
    .dbg_count(dbg_count)
  );

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        br;
    logic        tk;
  } ent_t;

  ent_t exp_q[$];
  logic m_ready;
  int   n_vec = 0;
  int   n_err = 0;

  // Condition flag picked by funct3[2:1] (00 eq, 10 ls, 11 lu, 01 reserved), inverted by funct3[0].
  function automatic logic ref_taken(input logic br, input logic [2:0] f3,
                                     input logic eq, input logic ls, input logic lu);
    logic flag;
    if (!br || f3[2:1] == 2'b01) return 1'b0;
    flag = (f3[2:1] == 2'b00) ? eq : (f3[2:1] == 2'b10) ? ls : lu;
    return flag ^ f3[0];
  endfunction

  task automatic drive(input logic v, input logic [63:0] s, input logic [4:0] rd,
                       input logic br, input logic [2:0] f3, input logic eq,
                       input logic ls, input logic lu, input logic ordy);
    in_valid = v; alu_s = s; in_rd = rd; in_is_branch = br; in_funct3 = f3;
    alu_eq = eq; alu_ls = ls; alu_lu = lu; out_ready = ordy;
  endtask

  // One clock: the model applies the same edge, then outputs are sampled 1 time unit later.
  task automatic tick();
    logic push, pop;
    ent_t e;
    push = in_valid && m_ready;
    pop  = (exp_q.size() != 0) && out_ready;
    e.result = alu_s; e.rd = in_rd; e.br = in_is_branch;
    e.tk = ref_taken(in_is_branch, in_funct3, alu_eq, alu_ls, alu_lu);
    @(posedge clk);
    if (flush_i) begin
      exp_q.delete();
      m_ready = 1'b1;
    end else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(e);
      m_ready = (exp_q.size() != 2);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 64'h0, 5'd0, 0, 3'b000, 0, 0, 0, 0);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if ({out_result, out_rd, out_is_branch, out_taken} !== '0) begin
      n_err++; $display("FAIL reset_out_data: got %h/%h/%b/%b expected all zero", out_result, out_rd, out_is_branch, out_taken);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_ready = 1'b1;
  endtask

  task automatic test_single_push();
    drive(1, 64'h1234, 5'd5, 0, 3'b000, 0, 0, 0, 1);
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_result !== 64'h1234 || out_rd !== 5'd5) begin
      n_err++; $display("FAIL single_push: got v=%b res=%h rd=%0d expected v=1 res=1234 rd=5", out_valid, out_result, out_rd);
    end
    drive(0, 64'h0, 5'd0, 0, 3'b000, 0, 0, 0, 1);
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_full_stall();
    drive(1, 64'd1, 5'd1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    drive(1, 64'd2, 5'd2, 0, 3'b000, 0, 0, 0, 0);
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    drive(1, 64'd3, 5'd3, 0, 3'b000, 0, 0, 0, 0);
    tick();
    n_vec++; if (out_result !== 64'd1 || dbg_count !== 2'd2) begin
      n_err++; $display("FAIL full_hold: got res=%0d count=%0d expected res=1 count=2", out_result, dbg_count);
    end
    drive(0, 64'h0, 5'd0, 0, 3'b000, 0, 0, 0, 1);
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_result !== 64'd2 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL full_pop1: got v=%b res=%0d rdy=%b expected v=1 res=2 rdy=1", out_valid, out_result, in_ready);
    end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_pop2: got out_valid=%b expected 0 (C dropped)", out_valid); end
  endtask

  task automatic test_branch();
    logic [2:0] f3_t [8] = '{3'b101, 3'b110, 3'b010, 3'b000, 3'b000, 3'b001, 3'b100, 3'b111};
    logic [3:0] fl_t [8] = '{4'b1010, 4'b1001, 4'b1111, 4'b0100, 4'b1100, 4'b1000, 4'b1010, 4'b1000};
    logic       ex_t [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // fl_t = {is_branch, eq, ls, lu}
    for (int i = 0; i < 8; i++) begin
      drive(1, 64'(100 + i), 5'(i), fl_t[i][3], f3_t[i], fl_t[i][2], fl_t[i][1], fl_t[i][0], 1);
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_taken !== ex_t[i] || out_is_branch !== fl_t[i][3]) begin
        n_err++; $display("FAIL branch_%0d: got v=%b taken=%b br=%b expected v=1 taken=%b br=%b",
                          i, out_valid, out_taken, out_is_branch, ex_t[i], fl_t[i][3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    n_vec++; if (dbg_count !== 2'd1) begin n_err++; $display("FAIL b2b_start_count: got %0d expected 1", dbg_count); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'(10 + i), 5'(i), 0, 3'b000, 0, 0, 0, 1);
      tick();
      n_vec++; if (out_result !== 64'(10 + i) || dbg_count !== 2'd1 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_%0d: got res=%0d count=%0d rdy=%b expected res=%0d count=1 rdy=1",
                          i, out_result, dbg_count, in_ready, 10 + i);
      end
    end
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_err;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 5'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
      tick();
      n_vec++; if (out_valid !== (exp_q.size() != 0) || in_ready !== m_ready || dbg_count !== 2'(exp_q.size())) begin
        n_err++; $display("FAIL rand_ctrl_%0d: got v=%b rdy=%b count=%0d expected v=%b rdy=%b count=%0d",
                          i, out_valid, in_ready, dbg_count, exp_q.size() != 0, m_ready, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        n_vec++; if ({out_result, out_rd, out_is_branch, out_taken} !== exp_q[0]) begin
          n_err++; $display("FAIL rand_head_%0d: got %h expected %h", i,
                            {out_result, out_rd, out_is_branch, out_taken}, exp_q[0]);
        end
      end
      if (n_err - errs_before > 10) break;
    end
  endtask

  task automatic test_reset_mid_full();
    for (int i = 0; i < 3 && exp_q.size() != 2; i++) begin
      drive(1, 64'hABCD_0000 + 64'(i), 5'd7, 0, 3'b000, 0, 0, 0, 0);
      tick();
    end
    n_vec++; if (dbg_count !== 2'd2) begin n_err++; $display("FAIL pre_reset_full: got count=%0d expected 2", dbg_count); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 64'h0) begin
      n_err++; $display("FAIL async_reset: got v=%b rdy=%b res=%h expected v=0 rdy=1 res=0", out_valid, in_ready, out_result);
    end
    #2 reset = 1'b0;
    exp_q.delete();
    m_ready = 1'b1;
  endtask

`ifdef EX_RESULT_BUF_FLUSH_EN
  task automatic test_flush();
    drive(1, 64'd21, 5'd1, 0, 3'b000, 0, 0, 0, 0);
    tick();
    drive(1, 64'd22, 5'd2, 0, 3'b000, 0, 0, 0, 0);
    tick();
    drive(1, 64'hDEAD, 5'd3, 0, 3'b000, 0, 0, 0, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    drive(0, 64'h0, 5'd0, 0, 3'b000, 0, 0, 0, 1);
    tick();
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop: got out_valid=%b expected 0", out_valid); end
    drive(1, 64'h77, 5'd9, 0, 3'b000, 0, 0, 0, 1);
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_result !== 64'h77) begin
      n_err++; $display("FAIL flush_resume: got v=%b res=%h expected v=1 res=77", out_valid, out_result);
    end
  endtask
`endif

  initial begin
    flush_i = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_single_push();
    test_full_stall();
    test_branch();
    test_back_to_back();
    test_random();
    test_reset_mid_full();
`ifdef EX_RESULT_BUF_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
